// File: rtl/nbit_register_file3_if.sv
// Bus bundle for nbit_register_file3: read ports, write-back port,
// scoreboard marking and the ready flag. The decode/write-back side
// holds the master modport and the register file holds the slave modport.
interface nbit_register_file3_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_sel_1;
  logic [ADDR_WIDTH-1:0] read_sel_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  RegWrite;
  logic                  pend_set;
  logic [ADDR_WIDTH-1:0] pend_address;
  logic                  pend_1;
  logic                  pend_2;
  logic                  ready;

  modport master (
    output read_sel_1, read_sel_2, write_address, write_data, RegWrite,
           pend_set, pend_address,
    input  read_data_1, read_data_2, pend_1, pend_2, ready
  );

  modport slave (
    input  read_sel_1, read_sel_2, write_address, write_data, RegWrite,
           pend_set, pend_address,
    output read_data_1, read_data_2, pend_1, pend_2, ready
  );
endinterface

// File: rtl/nbit_register_file3.sv
// Parametrised register file: two combinational read ports, one write
// port, a hardware clear sweep after reset, an optional hard-wired zero
// register, optional write-to-read bypass and a per-entry pending bit
// used by the control FSM to stall on operands not yet written back.
module nbit_register_file3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nbit_register_file3_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_next;
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  ready;
  logic                  hit_1;
  logic                  hit_2;

  // Entry 0 is treated as the hard-wired zero register when enabled.
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Control state: FSM state, sweep counter and scoreboard bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      count   <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pending <= pending_next;
    end
  end

  // Next-state logic: sweep zeros through storage, then serve write-back
  // and pend_set traffic. The set is applied after the clear so that a
  // same-cycle mark of the written register wins.
  always_comb begin
    state_next   = state;
    count_next   = count;
    pending_next = pending;
    mem_we       = 1'b0;
    mem_addr     = bus.write_address;
    mem_wdata    = bus.write_data;
    case (state)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_addr   = count;
        mem_wdata  = '0;
        count_next = count + 1'b1;
        if (&count) state_next = RUN;
      end
      RUN: begin
        if (bus.RegWrite && !is_zero(bus.write_address)) begin
          mem_we                          = 1'b1;
          pending_next[bus.write_address] = 1'b0;
        end
        if (bus.pend_set && !is_zero(bus.pend_address))
          pending_next[bus.pend_address] = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Storage has no reset of its own; a reset cycle suppresses the write so
  // in-flight traffic is discarded and the sweep restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign ready = (state == RUN);

  // Read ports: bypass first, then zero register / clear masking, then storage.
  always_comb begin
    hit_1 = BYPASS && ready && bus.RegWrite &&
            (bus.write_address == bus.read_sel_1) && !is_zero(bus.read_sel_1);
    hit_2 = BYPASS && ready && bus.RegWrite &&
            (bus.write_address == bus.read_sel_2) && !is_zero(bus.read_sel_2);
  end

  assign bus.read_data_1 = hit_1 ? bus.write_data :
                           (!ready || is_zero(bus.read_sel_1)) ? '0 : mem[bus.read_sel_1];
  assign bus.read_data_2 = hit_2 ? bus.write_data :
                           (!ready || is_zero(bus.read_sel_2)) ? '0 : mem[bus.read_sel_2];
  assign bus.pend_1      = ready && pending[bus.read_sel_1] && !hit_1;
  assign bus.pend_2      = ready && pending[bus.read_sel_2] && !hit_2;
  assign bus.ready       = ready;
endmodule

// File: tb/tb_nbit_register_file3.sv
// Bench for nbit_register_file3: a BYPASS=1 and a BYPASS=0 instance share
// the same stimulus; both are compared every cycle against a reference
// model, plus directed checks with literal expected values.
module tb_nbit_register_file3;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, wa, pa;
  logic [31:0] wd;
  logic        we, ps;

  always #5 clk = ~clk;

  nbit_register_file3_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  nbit_register_file3_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

  assign bus_a.read_sel_1    = rs1;
  assign bus_a.read_sel_2    = rs2;
  assign bus_a.write_address = wa;
  assign bus_a.write_data    = wd;
  assign bus_a.RegWrite      = we;
  assign bus_a.pend_set      = ps;
  assign bus_a.pend_address  = pa;
  assign bus_b.read_sel_1    = rs1;
  assign bus_b.read_sel_2    = rs2;
  assign bus_b.write_address = wa;
  assign bus_b.write_data    = wd;
  assign bus_b.RegWrite      = we;
  assign bus_b.pend_set      = ps;
  assign bus_b.pend_address  = pa;

  nbit_register_file3 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  nbit_register_file3 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Reference model: register contents and pending flags as a plain
  // array, plus the number of sweep cycles still owed after a reset.
  logic [31:0] mem_m [32];
  bit   [31:0] pend_m;
  int          sweep_left = 32;
  bit          armed = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic model_hit(input bit byp, input logic [4:0] sel);
    return byp && (sweep_left == 0) && we && (wa == sel) && (sel != 0);
  endfunction

  function automatic logic [31:0] model_rd(input bit byp, input logic [4:0] sel);
    if (model_hit(byp, sel)) return wd;
    if (sweep_left != 0 || sel == 0) return 32'h0;
    return mem_m[sel];
  endfunction

  function automatic logic model_pend(input bit byp, input logic [4:0] sel);
    return (sweep_left == 0) && pend_m[sel] && !model_hit(byp, sel);
  endfunction

  task automatic check_outputs();
    check("a_ready", {31'b0, bus_a.ready}, {31'b0, sweep_left == 0});
    check("a_rd1",   bus_a.read_data_1, model_rd(1'b1, rs1));
    check("a_rd2",   bus_a.read_data_2, model_rd(1'b1, rs2));
    check("a_pend1", {31'b0, bus_a.pend_1}, {31'b0, model_pend(1'b1, rs1)});
    check("a_pend2", {31'b0, bus_a.pend_2}, {31'b0, model_pend(1'b1, rs2)});
    check("b_ready", {31'b0, bus_b.ready}, {31'b0, sweep_left == 0});
    check("b_rd1",   bus_b.read_data_1, model_rd(1'b0, rs1));
    check("b_rd2",   bus_b.read_data_2, model_rd(1'b0, rs2));
    check("b_pend1", {31'b0, bus_b.pend_1}, {31'b0, model_pend(1'b0, rs1)});
    check("b_pend2", {31'b0, bus_b.pend_2}, {31'b0, model_pend(1'b0, rs2)});
  endtask

  task automatic update_model();
    if (!rst_n) begin
      armed      = 1'b1;
      sweep_left = 32;
      pend_m     = '0;
      for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      if (we && wa != 0) begin
        mem_m[wa]  = wd;
        pend_m[wa] = 1'b0;
      end
      if (ps && pa != 0) pend_m[pa] = 1'b1;
    end
  endtask

  // Inputs are driven at negedge; outputs checked 1 time unit later, the
  // model advances on the posedge, and control returns at the next negedge.
  task automatic cycle();
    #1;
    if (armed) check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0;
    ps = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs1 = '0; rs2 = '0; wa = '0; pa = '0; wd = '0;
    idle();
    @(negedge clk);

    // Reset sweep, with write/pend traffic to r3 that must be ignored.
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      we = (i == 4); wa = 5'd3; wd = 32'h1111_2222;
      ps = (i == 9); pa = 5'd3;
      #1 check("sweep_ready_low", {31'b0, bus_a.ready}, 32'd0);
      cycle();
    end
    idle();
    #1 check("ready_after_32", {31'b0, bus_a.ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1 check("cleared_entry", bus_a.read_data_1, 32'h0);
      cycle();
    end
    rs1 = 5'd3; rs2 = 5'd3;
    #1 check("clear_pend_r3", {31'b0, bus_a.pend_1}, 32'd0);

    // Plain write/read and the zero register.
    we = 1'b1; wa = 5'd7;  wd = 32'hDEAD_BEEF; cycle();
    we = 1'b1; wa = 5'd31; wd = 32'h1234_5678; cycle();
    idle(); rs1 = 5'd7; rs2 = 5'd31;
    #1 check("r7", bus_a.read_data_1, 32'hDEAD_BEEF);
    check("r31", bus_a.read_data_2, 32'h1234_5678);
    cycle();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; rs1 = 5'd0; cycle();
    idle();
    #1 check("r0_zero", bus_a.read_data_1, 32'h0);
    cycle();

    // Bypass versus no bypass.
    we = 1'b1; wa = 5'd5; wd = 32'hA5A5_A5A5; rs1 = 5'd5;
    #1 check("byp_same_cycle", bus_a.read_data_1, 32'hA5A5_A5A5);
    check("nobyp_old_value", bus_b.read_data_1, 32'h0);
    cycle();
    idle();
    #1 check("nobyp_next_cycle", bus_b.read_data_1, 32'hA5A5_A5A5);
    cycle();

    // Scoreboard.
    ps = 1'b1; pa = 5'd9; rs1 = 5'd9;
    #1 check("pend_before_set", {31'b0, bus_a.pend_1}, 32'd0);
    cycle();
    idle();
    #1 check("pend_after_set", {31'b0, bus_a.pend_1}, 32'd1);
    we = 1'b1; wa = 5'd9; wd = 32'h0000_0099;
    #1 check("pend_byp_hit", {31'b0, bus_a.pend_1}, 32'd0);
    check("pend_nobyp", {31'b0, bus_b.pend_1}, 32'd1);
    cycle();
    idle();
    #1 check("pend_cleared", {31'b0, bus_a.pend_1}, 32'd0);
    we = 1'b1; ps = 1'b1; wa = 5'd9; pa = 5'd9; wd = 32'h0000_0077; cycle();
    idle();
    #1 check("pend_set_wins", {31'b0, bus_a.pend_1}, 32'd1);
    check("data_still_written", bus_a.read_data_1, 32'h0000_0077);
    cycle();

    // Write r4, reset, then reset again mid-sweep at count 17.
    we = 1'b1; wa = 5'd4; wd = 32'hCAFE_F00D; cycle();
    idle(); rs1 = 5'd4;
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    repeat (17) cycle();
    rst_n = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'h5555_AAAA; cycle();
    rst_n = 1'b1; idle();
    for (int i = 0; i < 32; i++) begin
      #1 check("midsweep_ready_low", {31'b0, bus_a.ready}, 32'd0);
      cycle();
    end
    #1 check("midsweep_ready_high", {31'b0, bus_a.ready}, 32'd1);
    check("r4_cleared", bus_a.read_data_1, 32'h0);
    cycle();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      we    = $urandom_range(0, 1);
      ps    = ($urandom_range(0, 3) == 0);
      wa    = 5'($urandom_range(0, 31));
      wd    = $urandom;
      pa    = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rs1   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rs2   = ($urandom_range(0, 2) == 0) ? pa : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
